// File: rtl/regfile_pkg.sv
// regfile_pkg: shared command and state encodings for the multi-port register file.
//   MODE_* : encodings of the 2-bit i_mode command input.
//   state_e: clear-sequencer state (ST_CLEAR zeroes the array, ST_RUN serves traffic).
package regfile_pkg;

    localparam logic [1:0] MODE_IDLE  = 2'b00;
    localparam logic [1:0] MODE_WRITE = 2'b01;
    localparam logic [1:0] MODE_CLEAR = 2'b10;
    localparam logic [1:0] MODE_RSVD  = 2'b11;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_clr_ctrl.sv
// regfile_clr_ctrl: clear sequencer for regfile_mp.
// Walks clr_cnt over every entry after reset or a clear command, then enters RUN.
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   i_mode        : command input (only MODE_CLEAR matters here, and only in RUN)
//   o_ready       : state is RUN
//   o_busy        : state is CLEAR (always ~o_ready)
//   o_clr_we      : clear write strobe for the storage array
//   o_clr_addr    : entry being zeroed this cycle
module regfile_clr_ctrl
    import regfile_pkg::*;
#(
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        i_mode,
    output logic              o_ready,
    output logic              o_busy,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_addr
);

    localparam int               DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

    // Next-state logic: count through every entry in CLEAR, restart on a clear command in RUN.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + ADDR_ONE;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_RUN: begin
                if (i_mode == MODE_CLEAR) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = ADDR_ZERO;
                end else begin
                    state_d   = ST_RUN;
                    clr_cnt_d = clr_cnt_q;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = ADDR_ZERO;
            end
        endcase
    end

    // State and counter registers; reset restarts the clear from entry 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= ADDR_ZERO;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Status decodes come straight from the state register, so inputs never reach them.
    assign o_ready    = (state_q == ST_RUN);
    assign o_busy     = (state_q == ST_CLEAR);
    assign o_clr_we   = (state_q == ST_CLEAR);
    assign o_clr_addr = clr_cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: DEPTH x DATA_W register file with one write/command port and
// N_RD registered read ports, hardware clear sequencer and write-to-read bypass.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   i_mode     : 00 idle, 01 write, 10 clear-all, 11 reserved (raises o_err)
//   i_address  : write address;  i_data : write data
//   i_ren      : per-port read enable; i_raddr : packed read addresses
//   o_rdata    : packed registered read data; o_rvalid : per-port valid pulse
//   o_ready    : accepting commands/reads; o_busy : clearing
//   o_err      : one-cycle pulse for a reserved command accepted in RUN
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int N_RD   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               i_mode,
    input  logic [ADDR_W-1:0]        i_address,
    input  logic [DATA_W-1:0]        i_data,
    input  logic [N_RD-1:0]          i_ren,
    input  logic [N_RD*ADDR_W-1:0]   i_raddr,
    output logic [N_RD*DATA_W-1:0]   o_rdata,
    output logic [N_RD-1:0]          o_rvalid,
    output logic                     o_ready,
    output logic                     o_busy,
    output logic                     o_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              ready_s;
    logic              clr_we_s;
    logic [ADDR_W-1:0] clr_addr_s;
    logic              user_we_s;
    logic              wr_en_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [DATA_W-1:0] wr_data_s;
    logic              err_q;

    regfile_clr_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_clr_ctrl (
        .clk        (clk),
        .rst        (rst),
        .i_mode     (i_mode),
        .o_ready    (ready_s),
        .o_busy     (o_busy),
        .o_clr_we   (clr_we_s),
        .o_clr_addr (clr_addr_s)
    );

    assign o_ready   = ready_s;
    assign user_we_s = ready_s && (i_mode == MODE_WRITE);

    // Write mux: the clear sequencer owns the array in CLEAR, the user port in RUN; nothing writes under reset.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = i_address;
        wr_data_s = i_data;
        if (rst) begin
            wr_en_s = 1'b0;
        end else if (clr_we_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = clr_addr_s;
            wr_data_s = DATA_ZERO;
        end else begin
            wr_en_s = user_we_s;
        end
    end

    // Storage array; no reset, the clear sequencer zeroes it instead.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_addr_s] <= wr_data_s;
        end
    end

    // Reserved-command error pulse, only when the command is accepted in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= ready_s && (i_mode == MODE_RSVD);
        end
    end

    assign o_err = err_q;

    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] raddr_s;
        logic              hit_s;
        logic [DATA_W-1:0] rdata_q;
        logic              rvalid_q;

        assign raddr_s = i_raddr[k*ADDR_W +: ADDR_W];
        // A same-cycle user write to the read address forwards the new data.
        assign hit_s   = user_we_s && (i_address == raddr_s);

        // Read-port register: data holds when the port is idle or the array is clearing.
        always_ff @(posedge clk) begin
            if (rst) begin
                rdata_q  <= DATA_ZERO;
                rvalid_q <= 1'b0;
            end else if (ready_s && i_ren[k]) begin
                rdata_q  <= hit_s ? i_data : mem_q[raddr_s];
                rvalid_q <= 1'b1;
            end else begin
                rvalid_q <= 1'b0;
            end
        end

        assign o_rdata[k*DATA_W +: DATA_W] = rdata_q;
        assign o_rvalid[k]                 = rvalid_q;
    end

endmodule
